metric_pingpong_mem: RTL and testbench
======================================

METRIC_PINGPONG_MEM -- requirements
Module: metric_pingpong_mem

Interface
REQ-001 SHALL have parameter WD_METR, default 8: width of one ACS path metric.
REQ-002 SHALL have parameter N_ACS, default 4: number of metrics per stored word.
REQ-003 SHALL have parameter N_ITER, default 64: words per bank; even, power of two, at least 4.
REQ-004 SHALL have parameter NORM, default 1: 1 subtracts the read-bank minimum from read data; 0 returns raw data.
REQ-005 SHALL have derived AW = log2(N_ITER) and WW = WD_METR*N_ACS.
REQ-006 SHALL have port Clock, input, 1: all state changes on the rising edge.
REQ-007 SHALL have port Reset, input, 1: reset Reset, asynchronous, active-low.
REQ-008 SHALL have port WrValid, input, 1: write strobe.
REQ-009 SHALL have port WrAddr, input, AW: word address in the write bank.
REQ-010 SHALL have port WrData, input, WW: N_ACS metrics, with lane i at bits [i*WD_METR +: WD_METR].
REQ-011 SHALL have port Swap, input, 1: request to exchange the banks at the end of a trellis stage.
REQ-012 SHALL have port RdValid, input, 1: read strobe.
REQ-013 SHALL have port RdAddr, input, AW-1: pair address.
REQ-014 SHALL have port RdData, output, 2*WW: {word[2*RdAddr+1], word[2*RdAddr]} from the read bank.
REQ-015 SHALL have port RdDataValid, output, 1: RdData is valid.
REQ-016 SHALL have port ActiveBank, output, 1: current write bank (0=A, 1=B); the read bank is its complement.
REQ-017 SHALL have port WrCount, output, AW+1: accepted writes into the write bank since the last swap.
REQ-018 SHALL have port BankFull, output, 1: asserted when WrCount equals N_ITER.
REQ-019 SHALL have port RdBankMin, output, WD_METR: minimum lane value written into the current read bank.
REQ-020 SHALL have port SwapErr, output, 1: one-cycle pulse when a swap request is rejected.
REQ-021 SHALL have port OvfErr, output, 1: sticky flag, set on a write dropped because the bank was full.

Function
REQ-022 SHALL write WrData to bank[ActiveBank][WrAddr] and increment WrCount when WrValid is high and BankFull is low.
REQ-023 SHALL drop the write, keep WrCount unchanged, and set OvfErr when WrValid is high and BankFull is high.
REQ-024 SHALL count a duplicate-address write toward WrCount; the later data overwrites the earlier.
REQ-025 SHALL track WrMin, the running minimum over all N_ACS lanes of accepted writes since the last swap, unsigned; WrMin reinitialises to all-ones at each swap.
REQ-026 SHALL accept Swap only if the write count, including a same-cycle accepted write, equals N_ITER.
REQ-027 SHALL, on an accepted swap: toggle ActiveBank; clear WrCount to 0; load RdBankMin from WrMin, including any same-cycle write; set RdBankValid.
REQ-028 SHALL, on a rejected swap: pulse SwapErr high for exactly one cycle and change no other state.
REQ-029 SHALL give reads a latency of 1 cycle: RdValid at cycle n produces RdData and RdDataValid at cycle n+1.
REQ-030 SHALL deassert RdDataValid and drive RdData to 0 in every cycle not preceded by a valid read.
REQ-031 SHALL treat a read as invalid (RdDataValid=0, RdData=0) while RdBankValid is 0, i.e. before the first accepted swap.
REQ-032 SHALL sample the read-bank select at the RdValid cycle: a swap in the same cycle does not affect that read.
REQ-033 SHALL, with NORM=1, output each lane as stored value minus RdBankMin, modulo 2^WD_METR; no saturation is needed because the stored value is never below the minimum.
REQ-034 SHALL never let a write alter the read bank: the read and write banks are always disjoint.

Reset
REQ-035 SHALL, while Reset is low: zero both banks; set ActiveBank=0, WrCount=0, WrMin=all-ones, RdBankMin=0, RdBankValid=0; clear RdData, RdDataValid, SwapErr and OvfErr.
REQ-036 SHALL, on Reset low mid-stage, abandon the partial stage and discard any read in flight without producing output.
REQ-037 SHALL release from reset synchronously, with the first write accepted on the first rising edge after Reset rises.

Verification (WD_METR=8, N_ACS=4, N_ITER=64)
REQ-038 SHALL cover: write 64 words (word k = lanes k+10), Swap, then RdAddr=0 with NORM=1 -> next cycle RdDataValid=1, RdData lanes {1,1,1,1,0,0,0,0}, RdBankMin=10, ActiveBank=1.
REQ-039 SHALL cover: Swap after 63 writes -> SwapErr for 1 cycle, ActiveBank unchanged, WrCount=63; the 64th write and Swap in the same cycle are then accepted and WrCount=0.
REQ-040 SHALL cover: a 65th write before swap -> dropped, OvfErr=1 and held, bank contents unchanged.
REQ-041 SHALL cover: RdValid before the first swap -> RdDataValid=0, RdData=0.
REQ-042 SHALL cover: RdValid and an accepted Swap in the same cycle -> the read returns old read-bank data, and the following read returns the new bank.
REQ-043 SHALL cover: Reset pulsed low after 30 writes -> WrCount=0, ActiveBank=0, RdBankValid=0, and all outputs 0 except BankFull=0.

Source files
------------

// File: rtl/metric_pingpong_mem_if.sv
// Bus bundle for the ping-pong path-metric store: write port, swap request,
// pair-read port and status. Clock and reset stay outside the bundle.
interface metric_pingpong_mem_if #(
    parameter int WD_METR = 8,
    parameter int N_ACS   = 4,
    parameter int N_ITER  = 64
);
    localparam int AW = $clog2(N_ITER);
    localparam int WW = WD_METR * N_ACS;

    logic                WrValid;
    logic [AW-1:0]       WrAddr;
    logic [WW-1:0]       WrData;
    logic                Swap;
    logic                RdValid;
    logic [AW-2:0]       RdAddr;
    logic [2*WW-1:0]     RdData;
    logic                RdDataValid;
    logic                ActiveBank;
    logic [AW:0]         WrCount;
    logic                BankFull;
    logic [WD_METR-1:0]  RdBankMin;
    logic                SwapErr;
    logic                OvfErr;

    modport master (
        output WrValid, WrAddr, WrData, Swap, RdValid, RdAddr,
        input  RdData, RdDataValid, ActiveBank, WrCount, BankFull,
               RdBankMin, SwapErr, OvfErr
    );

    modport slave (
        input  WrValid, WrAddr, WrData, Swap, RdValid, RdAddr,
        output RdData, RdDataValid, ActiveBank, WrCount, BankFull,
               RdBankMin, SwapErr, OvfErr
    );
endinterface

// File: rtl/metric_pingpong_mem.sv
// Two-bank path-metric store: one bank fills during a trellis stage while the
// other is read as normalised metric pairs; banks exchange on an accepted swap.
module metric_pingpong_mem #(
    parameter int WD_METR = 8,
    parameter int N_ACS   = 4,
    parameter int N_ITER  = 64,
    parameter int NORM    = 1,
    localparam int AW     = $clog2(N_ITER),
    localparam int WW     = WD_METR * N_ACS
) (
    input  logic                     Clock,
    input  logic                     Reset,
    metric_pingpong_mem_if.slave     bus
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(N_ITER);

    logic [WW-1:0]      mem_q [2][N_ITER];

    logic               active_q, active_d;
    logic [AW:0]        wr_count_q, wr_count_d;
    logic [WD_METR-1:0] wr_min_q, wr_min_d;
    logic [WD_METR-1:0] rd_min_q, rd_min_d;
    logic               rd_bank_valid_q, rd_bank_valid_d;
    logic               swap_err_q, swap_err_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic [2*WW-1:0]    rd_data_q, rd_data_d;

    logic               bank_full;
    logic               wr_acc;
    logic               swap_ok;
    logic [AW:0]        cnt_next;
    logic [WD_METR-1:0] lane_min;
    logic [WD_METR-1:0] min_next;
    logic [AW-1:0]      rd_lo_addr;
    logic [AW-1:0]      rd_hi_addr;
    logic [2*WW-1:0]    rd_raw;

    always_comb begin
        bank_full = (wr_count_q == FULL_CNT);
        wr_acc    = bus.WrValid && !bank_full;
        cnt_next  = wr_count_q + (AW+1)'(wr_acc);
        // A write landing in the same cycle counts toward the swap condition.
        swap_ok   = bus.Swap && (cnt_next == FULL_CNT);

        lane_min = '1;
        for (int i = 0; i < N_ACS; i++) begin
            if (bus.WrData[i*WD_METR +: WD_METR] < lane_min) begin
                lane_min = bus.WrData[i*WD_METR +: WD_METR];
            end
        end
        min_next = (wr_acc && (lane_min < wr_min_q)) ? lane_min : wr_min_q;

        active_d        = active_q;
        wr_count_d      = cnt_next;
        wr_min_d        = min_next;
        rd_min_d        = rd_min_q;
        rd_bank_valid_d = rd_bank_valid_q;
        if (swap_ok) begin
            active_d        = ~active_q;
            wr_count_d      = '0;
            wr_min_d        = '1;
            rd_min_d        = min_next;
            rd_bank_valid_d = 1'b1;
        end

        swap_err_d = bus.Swap && !swap_ok;
        ovf_d      = ovf_q || (bus.WrValid && bank_full);

        // Read uses the pre-edge bank select and minimum, so a same-cycle swap
        // still returns the outgoing read bank.
        rd_lo_addr = {bus.RdAddr, 1'b0};
        rd_hi_addr = {bus.RdAddr, 1'b1};
        rd_raw     = {mem_q[~active_q][rd_hi_addr], mem_q[~active_q][rd_lo_addr]};
        rd_valid_d = bus.RdValid && rd_bank_valid_q;
        rd_data_d  = '0;
        if (rd_valid_d) begin
            for (int j = 0; j < 2*N_ACS; j++) begin
                if (NORM != 0) begin
                    rd_data_d[j*WD_METR +: WD_METR] = rd_raw[j*WD_METR +: WD_METR] - rd_min_q;
                end else begin
                    rd_data_d[j*WD_METR +: WD_METR] = rd_raw[j*WD_METR +: WD_METR];
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            active_q        <= 1'b0;
            wr_count_q      <= '0;
            wr_min_q        <= '1;
            rd_min_q        <= '0;
            rd_bank_valid_q <= 1'b0;
            swap_err_q      <= 1'b0;
            ovf_q           <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            active_q        <= active_d;
            wr_count_q      <= wr_count_d;
            wr_min_q        <= wr_min_d;
            rd_min_q        <= rd_min_d;
            rd_bank_valid_q <= rd_bank_valid_d;
            swap_err_q      <= swap_err_d;
            ovf_q           <= ovf_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < N_ITER; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
        end else if (wr_acc) begin
            mem_q[active_q][bus.WrAddr] <= bus.WrData;
        end
    end

    assign bus.RdData      = rd_data_q;
    assign bus.RdDataValid = rd_valid_q;
    assign bus.ActiveBank  = active_q;
    assign bus.WrCount     = wr_count_q;
    assign bus.BankFull    = bank_full;
    assign bus.RdBankMin   = rd_min_q;
    assign bus.SwapErr     = swap_err_q;
    assign bus.OvfErr      = ovf_q;

endmodule

// File: tb/tb_metric_pingpong_mem.sv
// Directed and randomised bench for metric_pingpong_mem against a stage-level
// model: a filling stage and a readable stage that trade places on a swap.
module tb_metric_pingpong_mem;
    localparam int W  = 8;
    localparam int NA = 4;
    localparam int NI = 64;
    localparam int WW = W * NA;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    metric_pingpong_mem_if #(.WD_METR(W), .N_ACS(NA), .N_ITER(NI)) bus ();

    metric_pingpong_mem #(.WD_METR(W), .N_ACS(NA), .N_ITER(NI), .NORM(1)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: the stage being filled, the stage being read, and stage status.
    logic [WW-1:0]   m_fill [NI];
    logic [WW-1:0]   m_read [NI];
    int              m_cnt;
    int              m_min;
    int              m_rdmin;
    bit              m_active;
    bit              m_rdv;
    bit              m_ovf;
    bit              m_swerr;
    bit              e_rdv;
    logic [2*WW-1:0] e_rd;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NI; i++) begin
            m_fill[i] = '0;
            m_read[i] = '0;
        end
        m_cnt = 0; m_min = 255; m_rdmin = 0;
        m_active = 0; m_rdv = 0; m_ovf = 0; m_swerr = 0;
        e_rdv = 0; e_rd = '0;
    endtask

    function automatic logic [2*WW-1:0] norm_pair(int a);
        logic [2*WW-1:0] r;
        logic [WW-1:0]   lo, hi;
        lo = m_read[2*a];
        hi = m_read[2*a+1];
        for (int l = 0; l < NA; l++) begin
            r[l*W +: W]      = W'((int'(lo[l*W +: W]) - m_rdmin) % 256);
            r[WW + l*W +: W] = W'((int'(hi[l*W +: W]) - m_rdmin) % 256);
        end
        return r;
    endfunction

    task automatic compare_all();
        check("ActiveBank",  64'(bus.ActiveBank),  64'(m_active));
        check("WrCount",     64'(bus.WrCount),     64'(m_cnt));
        check("BankFull",    64'(bus.BankFull),    64'(m_cnt == NI));
        check("RdBankMin",   64'(bus.RdBankMin),   64'(m_rdmin));
        check("SwapErr",     64'(bus.SwapErr),     64'(m_swerr));
        check("OvfErr",      64'(bus.OvfErr),      64'(m_ovf));
        check("RdDataValid", 64'(bus.RdDataValid), 64'(e_rdv));
        check("RdData",      64'(bus.RdData),      64'(e_rd));
    endtask

    task automatic cycle(bit wv, int wa, logic [WW-1:0] wd, bit sw, bit rv, int ra);
        logic [WW-1:0] tmp;
        bus.WrValid = wv;
        bus.WrAddr  = 6'(wa);
        bus.WrData  = wd;
        bus.Swap    = sw;
        bus.RdValid = rv;
        bus.RdAddr  = 5'(ra);

        e_rdv = rv && m_rdv;
        e_rd  = e_rdv ? norm_pair(ra) : '0;
        if (wv) begin
            if (m_cnt < NI) begin
                m_fill[wa] = wd;
                m_cnt++;
                for (int l = 0; l < NA; l++)
                    if (int'(wd[l*W +: W]) < m_min) m_min = int'(wd[l*W +: W]);
            end else begin
                m_ovf = 1;
            end
        end
        m_swerr = 0;
        if (sw) begin
            if (m_cnt == NI) begin
                for (int i = 0; i < NI; i++) begin
                    tmp = m_fill[i]; m_fill[i] = m_read[i]; m_read[i] = tmp;
                end
                m_active = !m_active;
                m_cnt    = 0;
                m_rdmin  = m_min;
                m_min    = 255;
                m_rdv    = 1;
            end else begin
                m_swerr = 1;
            end
        end

        @(posedge Clock);
        #1;
        bus.WrValid = 0; bus.Swap = 0; bus.RdValid = 0;
        compare_all();
    endtask

    initial begin
        int guard;
        bus.WrValid = 0; bus.WrAddr = '0; bus.WrData = '0;
        bus.Swap = 0; bus.RdValid = 0; bus.RdAddr = '0;
        reset_model();

        #3;
        compare_all();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;

        // Read before any swap is ignored.
        cycle(0, 0, '0, 0, 1, 3);
        check("pre_swap_rdvalid", 64'(bus.RdDataValid), 64'd0);

        for (int k = 0; k < NI; k++)
            cycle(1, k, {4{8'(k + 10)}}, 0, 1, $urandom_range(0, 31));
        cycle(0, 0, '0, 1, 0, 0);
        check("first_swap_bank", 64'(bus.ActiveBank), 64'd1);
        cycle(0, 0, '0, 0, 1, 0);
        check("first_read_data", 64'(bus.RdData), 64'h01010101_00000000);
        check("first_read_min",  64'(bus.RdBankMin), 64'd10);
        check("first_read_vld",  64'(bus.RdDataValid), 64'd1);

        // Random fill with duplicate addresses, reads of the other bank alongside.
        for (int k = 0; k < NI; k++)
            cycle(1, $urandom_range(0, NI-1), $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 31));
        cycle(1, 7, 32'hDEAD_0001, 0, 0, 0);
        check("ovf_set", 64'(bus.OvfErr), 64'd1);
        cycle(0, 0, '0, 0, 0, 0);
        check("ovf_held", 64'(bus.OvfErr), 64'd1);

        // Same-cycle read and swap: old bank first, new bank next.
        cycle(0, 0, '0, 1, 1, 5);
        cycle(0, 0, '0, 0, 1, 5);
        for (int a = 0; a < NI/2; a++)
            cycle(0, 0, '0, 0, 1, a);

        for (int k = 0; k < NI-1; k++)
            cycle(1, $urandom_range(0, NI-1), $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 31));
        cycle(0, 0, '0, 1, 0, 0);
        check("early_swap_err",   64'(bus.SwapErr), 64'd1);
        check("early_swap_count", 64'(bus.WrCount), 64'd63);
        cycle(0, 0, '0, 0, 0, 0);
        check("swap_err_pulse",   64'(bus.SwapErr), 64'd0);
        cycle(1, 3, $urandom, 1, 0, 0);
        check("late_swap_count",  64'(bus.WrCount), 64'd0);

        for (int n = 0; n < 600; n++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, NI-1), $urandom,
                  (m_cnt >= NI-2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 31));

        guard = 0;
        while (m_cnt < NI && guard < 200) begin
            cycle(1, $urandom_range(0, NI-1), $urandom, 0, 0, 0);
            guard++;
        end
        check("fill_guard", 64'(guard < 200), 64'd1);
        cycle(0, 0, '0, 1, 0, 0);
        for (int k = 0; k < 30; k++)
            cycle(1, k, $urandom, 0, k == 29, 9);

        // Reset mid-stage with a read result pending.
        Reset = 1'b0;
        #1;
        reset_model();
        compare_all();
        check("rst_bankfull", 64'(bus.BankFull), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        cycle(1, 0, 32'h0403_0201, 0, 1, 0);
        check("post_rst_write", 64'(bus.WrCount), 64'd1);
        check("post_rst_read",  64'(bus.RdDataValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
